// File: rtl/wb_rr_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_bus_arbiter
//   Round-robin Wishbone bus arbiter for the shared node bus. Masters request
//   the bus by raising CYC. The winner receives a one-hot registered grant,
//   which it holds for its whole bus cycle. A watchdog takes back a grant that
//   has been held for too long.
//
// Request/grant handshake:
//   A master asks for the bus by holding cyc_i[k]=1. A request seen at a rising
//   edge while the arbiter is idle produces a grant that is visible right after
//   that edge. The owner keeps the grant for as long as it holds cyc_i[k]=1.
//   Dropping cyc_i[k] releases the bus at the next edge. At least one cycle
//   with gnt_o=0 always separates two tenures. A request that is withdrawn
//   before it is granted is forgotten. There is no preemption.
//
// Ports:
//   clk         in   1              rising-edge clock
//   rst         in   1              asynchronous reset, active-high
//   cyc_i       in   N_MASTERS      per-master bus request (master CYC_O)
//   gnt_o       out  N_MASTERS      one-hot registered grant (or all zero)
//   gnt_id_o    out  N_BITS_MASTER  owner index, meaningful while bus_busy_o=1
//   bus_busy_o  out  1              |gnt_o
//   timeout_o   out  1              one-cycle pulse when the watchdog revokes
//   dbg_state_o out  1              FSM state (0=IDLE, 1=OWNED)
// -----------------------------------------------------------------------------
module wb_rr_bus_arbiter #(
  parameter int N_MASTERS        = 2,
  parameter int N_BITS_MASTER    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
  parameter int MAX_GRANT_CYCLES = 64,
  parameter int N_BITS_WDOG      = $clog2(MAX_GRANT_CYCLES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_MASTERS-1:0]     cyc_i,
  output logic [N_MASTERS-1:0]     gnt_o,
  output logic [N_BITS_MASTER-1:0] gnt_id_o,
  output logic                     bus_busy_o,
  output logic                     timeout_o,
  output logic                     dbg_state_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  localparam logic [N_BITS_WDOG-1:0]   WDOG_LAST = N_BITS_WDOG'(MAX_GRANT_CYCLES - 1);
  localparam logic [N_BITS_MASTER-1:0] LAST_IDX  = N_BITS_MASTER'(N_MASTERS - 1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [N_MASTERS-1:0]     r_gnt;
  logic [N_MASTERS-1:0]     w_gnt_nxt;
  logic [N_BITS_MASTER-1:0] r_gnt_id;
  logic [N_BITS_MASTER-1:0] w_gnt_id_nxt;
  logic [N_BITS_MASTER-1:0] r_last_owner;
  logic [N_BITS_MASTER-1:0] w_last_owner_nxt;
  logic [N_BITS_WDOG-1:0]   r_wdog;
  logic [N_BITS_WDOG-1:0]   w_wdog_nxt;
  logic                     r_timeout;
  logic                     w_timeout_nxt;

  logic [N_BITS_MASTER-1:0] w_winner;
  logic                     w_any_req;
  logic                     w_owner_req;
  logic                     w_wdog_expired;

  // Round-robin search starting just after the last owner. Walking from the
  // farthest candidate to the nearest lets the nearest requester overwrite the
  // others. The index wraps by conditional subtraction, so a non-power-of-2
  // master count never yields an out-of-range index.
  always_comb begin
    w_winner  = '0;
    w_any_req = 1'b0;
    for (int i = N_MASTERS; i >= 1; i--) begin
      if (cyc_i[((int'(r_last_owner) + i) >= N_MASTERS) ?
                (int'(r_last_owner) + i - N_MASTERS) :
                (int'(r_last_owner) + i)]) begin
        w_winner  = N_BITS_MASTER'(((int'(r_last_owner) + i) >= N_MASTERS) ?
                                   (int'(r_last_owner) + i - N_MASTERS) :
                                   (int'(r_last_owner) + i));
        w_any_req = 1'b1;
      end
    end
  end

  // r_gnt is one-hot on the owner while OWNED, so this masks out the others.
  assign w_owner_req    = |(cyc_i & r_gnt);
  assign w_wdog_expired = (r_wdog >= WDOG_LAST);

  // State register and the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_gnt_id     <= '0;
      r_last_owner <= LAST_IDX;
      r_wdog       <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_gnt        <= w_gnt_nxt;
      r_gnt_id     <= w_gnt_id_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_wdog       <= w_wdog_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_state_nxt = ST_OWNED;
      end
      ST_OWNED: begin
        if (!w_owner_req || w_wdog_expired) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic. It computes the values that the grant, watchdog and pulse
  // registers load at the next edge.
  always_comb begin
    w_gnt_nxt        = r_gnt;
    w_gnt_id_nxt     = r_gnt_id;
    w_last_owner_nxt = r_last_owner;
    w_wdog_nxt       = r_wdog;
    w_timeout_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt = '0;
        if (w_any_req) begin
          w_gnt_nxt        = N_MASTERS'(1) << w_winner;
          w_gnt_id_nxt     = w_winner;
          w_last_owner_nxt = w_winner;
          w_wdog_nxt       = '0;
        end
      end
      ST_OWNED: begin
        if (!w_owner_req) begin
          // A normal release takes precedence over a coincident timeout.
          w_gnt_nxt = '0;
        end else if (w_wdog_expired) begin
          // last_owner keeps the revoked master, so it has the lowest priority.
          w_gnt_nxt     = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          // The expired check above keeps the count from ever passing WDOG_LAST.
          w_wdog_nxt = r_wdog + N_BITS_WDOG'(1);
        end
      end
      default: w_gnt_nxt = '0;
    endcase
  end

  assign gnt_o       = r_gnt;
  assign gnt_id_o    = r_gnt_id;
  assign bus_busy_o  = |r_gnt;
  assign timeout_o   = r_timeout;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_wb_rr_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_rr_bus_arbiter
//   Self-checking bench for wb_rr_bus_arbiter. It uses one 2-master instance
//   and one 3-master instance, both with an 8-cycle watchdog. Each test plans
//   a per-cycle table of (cyc_i, expected outputs). When a row is driven, its
//   expectation is pushed into exp_q. After the clock edge it is popped and
//   compared with the DUT outputs.
//   Expectation encoding: bit7 = timeout, bits6:5 = gnt_id, bits2:0 = gnt.
// -----------------------------------------------------------------------------
module tb_wb_rr_bus_arbiter;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [1:0] cyc2;
  logic [1:0] gnt2;
  logic       id2;
  logic       busy2;
  logic       to2;
  logic       st2;

  logic [2:0] cyc3;
  logic [2:0] gnt3;
  logic [1:0] id3;
  logic       busy3;
  logic       to3;
  logic       st3;

  wb_rr_bus_arbiter #(
    .N_MASTERS(2),
    .MAX_GRANT_CYCLES(8)
  ) u_dut2 (
    .clk(clk),
    .rst(rst),
    .cyc_i(cyc2),
    .gnt_o(gnt2),
    .gnt_id_o(id2),
    .bus_busy_o(busy2),
    .timeout_o(to2),
    .dbg_state_o(st2)
  );

  wb_rr_bus_arbiter #(
    .N_MASTERS(3),
    .MAX_GRANT_CYCLES(8)
  ) u_dut3 (
    .clk(clk),
    .rst(rst),
    .cyc_i(cyc3),
    .gnt_o(gnt3),
    .gnt_id_o(id3),
    .bus_busy_o(busy3),
    .timeout_o(to3),
    .dbg_state_o(st3)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [2:0]   plan_cyc[$];
  logic [W-1:0] plan_exp[$];
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- driver tasks ----------------
  task automatic plan(input logic [2:0] c, input logic to, input logic [1:0] id,
                      input logic [2:0] g);
    plan_cyc.push_back(c);
    plan_exp.push_back({to, id, 2'b00, g});
  endtask

  task automatic do_reset();
    cyc2 = 2'b00;
    cyc3 = 3'b000;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [2:0]   c;
    logic [W-1:0] e;
    int           cyc_n;
    rst  = 1'b1;
    cyc2 = 2'b11;
    cyc3 = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({gnt2, busy2, to2, st2} !== 5'b0 || {gnt3, busy3, to3} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: gnt2=%b busy2=%b to2=%b st2=%b gnt3=%b, want all 0",
                 i, gnt2, busy2, to2, st2, gnt3);
      end
    end
    rst  = 1'b0;
    cyc3 = 3'b000;
    plan(3'b011, 1'b0, 2'd0, 3'b001);
    plan(3'b000, 1'b0, 2'd0, 3'b000);
    plan(3'b000, 1'b0, 2'd0, 3'b000);
    cyc_n = 0;
    while (plan_cyc.size() > 0) begin
      c = plan_cyc.pop_front();
      cyc2 = c[1:0];
      exp_q.push_back(plan_exp.pop_front());
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({to2, busy2, gnt2} !== {e[7], |e[1:0], e[1:0]}) begin
        n_fail++;
        $display("FAIL reset_release cyc %0d: to/busy/gnt=%b/%b/%b, want %b/%b/%b",
                 cyc_n, to2, busy2, gnt2, e[7], |e[1:0], e[1:0]);
      end
      if (e[1:0] != 2'b00) begin
        n_checks++;
        if (id2 !== e[5]) begin
          n_fail++;
          $display("FAIL reset_release_id cyc %0d: id=%0d, want %0d", cyc_n, id2, e[5]);
        end
      end
      cyc_n++;
    end
  endtask

  task automatic test_alternation();
    logic [2:0]   c;
    logic [W-1:0] e;
    int           cyc_n;
    do_reset();
    for (int t = 0; t < 4; t++) begin
      // Grant is seen after the first row. The owner holds CYC for three
      // cycles and then drops it for one cycle while the other keeps asking.
      plan(3'b011, 1'b0, 2'(t % 2), 3'(t % 2 == 0 ? 1 : 2));
      plan(3'b011, 1'b0, 2'(t % 2), 3'(t % 2 == 0 ? 1 : 2));
      plan(3'b011, 1'b0, 2'(t % 2), 3'(t % 2 == 0 ? 1 : 2));
      plan(3'(t % 2 == 0 ? 2 : 1), 1'b0, 2'd0, 3'b000);
    end
    plan(3'b000, 1'b0, 2'd0, 3'b000);
    cyc_n = 0;
    while (plan_cyc.size() > 0) begin
      c = plan_cyc.pop_front();
      cyc2 = c[1:0];
      exp_q.push_back(plan_exp.pop_front());
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({to2, busy2, gnt2} !== {e[7], |e[1:0], e[1:0]}) begin
        n_fail++;
        $display("FAIL alternation cyc %0d: to/busy/gnt=%b/%b/%b, want %b/%b/%b",
                 cyc_n, to2, busy2, gnt2, e[7], |e[1:0], e[1:0]);
      end
      if (e[1:0] != 2'b00) begin
        n_checks++;
        if (id2 !== e[5]) begin
          n_fail++;
          $display("FAIL alternation_id cyc %0d: id=%0d, want %0d", cyc_n, id2, e[5]);
        end
      end
      cyc_n++;
    end
  endtask

  task automatic test_no_preempt();
    logic [2:0]   c;
    logic [W-1:0] e;
    int           cyc_n;
    do_reset();
    plan(3'b001, 1'b0, 2'd0, 3'b001);
    plan(3'b001, 1'b0, 2'd0, 3'b001);
    plan(3'b011, 1'b0, 2'd0, 3'b001);
    plan(3'b011, 1'b0, 2'd0, 3'b001);
    plan(3'b010, 1'b0, 2'd0, 3'b000);
    plan(3'b010, 1'b0, 2'd1, 3'b010);
    plan(3'b010, 1'b0, 2'd1, 3'b010);
    plan(3'b000, 1'b0, 2'd0, 3'b000);
    plan(3'b000, 1'b0, 2'd0, 3'b000);
    cyc_n = 0;
    while (plan_cyc.size() > 0) begin
      c = plan_cyc.pop_front();
      cyc2 = c[1:0];
      exp_q.push_back(plan_exp.pop_front());
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({to2, busy2, gnt2} !== {e[7], |e[1:0], e[1:0]}) begin
        n_fail++;
        $display("FAIL no_preempt cyc %0d: to/busy/gnt=%b/%b/%b, want %b/%b/%b",
                 cyc_n, to2, busy2, gnt2, e[7], |e[1:0], e[1:0]);
      end
      if (e[1:0] != 2'b00) begin
        n_checks++;
        if (id2 !== e[5]) begin
          n_fail++;
          $display("FAIL no_preempt_id cyc %0d: id=%0d, want %0d", cyc_n, id2, e[5]);
        end
      end
      cyc_n++;
    end
  endtask

  task automatic test_watchdog();
    logic [2:0]   c;
    logic [W-1:0] e;
    int           cyc_n;
    do_reset();
    // M0 holds CYC indefinitely and M1 also requests. The grant lasts 8
    // cycles, the watchdog fires, and M1 is granted next.
    for (int i = 0; i < 8; i++) plan(3'b011, 1'b0, 2'd0, 3'b001);
    plan(3'b011, 1'b1, 2'd0, 3'b000);
    plan(3'b011, 1'b0, 2'd1, 3'b010);
    plan(3'b001, 1'b0, 2'd0, 3'b000);
    plan(3'b001, 1'b0, 2'd0, 3'b001);
    // M0 is the only requester: it times out and is granted again after
    // the dead cycle.
    for (int i = 0; i < 7; i++) plan(3'b001, 1'b0, 2'd0, 3'b001);
    plan(3'b001, 1'b1, 2'd0, 3'b000);
    plan(3'b001, 1'b0, 2'd0, 3'b001);
    plan(3'b000, 1'b0, 2'd0, 3'b000);
    plan(3'b000, 1'b0, 2'd0, 3'b000);
    cyc_n = 0;
    while (plan_cyc.size() > 0) begin
      c = plan_cyc.pop_front();
      cyc2 = c[1:0];
      exp_q.push_back(plan_exp.pop_front());
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({to2, busy2, gnt2} !== {e[7], |e[1:0], e[1:0]}) begin
        n_fail++;
        $display("FAIL watchdog cyc %0d: to/busy/gnt=%b/%b/%b, want %b/%b/%b",
                 cyc_n, to2, busy2, gnt2, e[7], |e[1:0], e[1:0]);
      end
      if (e[1:0] != 2'b00) begin
        n_checks++;
        if (id2 !== e[5]) begin
          n_fail++;
          $display("FAIL watchdog_id cyc %0d: id=%0d, want %0d", cyc_n, id2, e[5]);
        end
      end
      cyc_n++;
    end
  endtask

  task automatic test_wrap3();
    logic [2:0]   c;
    logic [W-1:0] e;
    int           cyc_n;
    do_reset();
    // All three masters request. Each owner drops CYC after one granted
    // cycle. Expected grant order is 0,1,2,0,1.
    plan(3'b111, 1'b0, 2'd0, 3'b001);
    plan(3'b110, 1'b0, 2'd0, 3'b000);
    plan(3'b111, 1'b0, 2'd1, 3'b010);
    plan(3'b101, 1'b0, 2'd0, 3'b000);
    plan(3'b111, 1'b0, 2'd2, 3'b100);
    plan(3'b011, 1'b0, 2'd0, 3'b000);
    plan(3'b111, 1'b0, 2'd0, 3'b001);
    plan(3'b110, 1'b0, 2'd0, 3'b000);
    plan(3'b111, 1'b0, 2'd1, 3'b010);
    plan(3'b101, 1'b0, 2'd0, 3'b000);
    plan(3'b000, 1'b0, 2'd0, 3'b000);
    cyc_n = 0;
    while (plan_cyc.size() > 0) begin
      c = plan_cyc.pop_front();
      cyc3 = c;
      exp_q.push_back(plan_exp.pop_front());
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({to3, busy3, gnt3} !== {e[7], |e[2:0], e[2:0]}) begin
        n_fail++;
        $display("FAIL wrap3 cyc %0d: to/busy/gnt=%b/%b/%b, want %b/%b/%b",
                 cyc_n, to3, busy3, gnt3, e[7], |e[2:0], e[2:0]);
      end
      if (e[2:0] != 3'b000) begin
        n_checks++;
        if (id3 !== e[6:5]) begin
          n_fail++;
          $display("FAIL wrap3_id cyc %0d: id=%0d, want %0d", cyc_n, id3, e[6:5]);
        end
      end
      cyc_n++;
    end
  endtask

  task automatic test_async_reset();
    logic [2:0]   c;
    logic [W-1:0] e;
    int           cyc_n;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        plan(3'b010, 1'b0, 2'd1, 3'b010);
        plan(3'b010, 1'b0, 2'd1, 3'b010);
      end else begin
        plan(3'b011, 1'b0, 2'd0, 3'b001);
        plan(3'b010, 1'b0, 2'd0, 3'b000);
        plan(3'b000, 1'b0, 2'd0, 3'b000);
      end
      cyc_n = 0;
      while (plan_cyc.size() > 0) begin
        c = plan_cyc.pop_front();
        cyc2 = c[1:0];
        exp_q.push_back(plan_exp.pop_front());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if ({to2, busy2, gnt2} !== {e[7], |e[1:0], e[1:0]}) begin
          n_fail++;
          $display("FAIL async_reset p%0d cyc %0d: to/busy/gnt=%b/%b/%b, want %b/%b/%b",
                   pass, cyc_n, to2, busy2, gnt2, e[7], |e[1:0], e[1:0]);
        end
        if (e[1:0] != 2'b00) begin
          n_checks++;
          if (id2 !== e[5]) begin
            n_fail++;
            $display("FAIL async_reset_id p%0d cyc %0d: id=%0d, want %0d",
                     pass, cyc_n, id2, e[5]);
          end
        end
        cyc_n++;
      end
      if (pass == 0) begin
        // Pulse reset between edges while M1 owns the bus.
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (gnt2 !== 2'b00 || busy2 !== 1'b0) begin
          n_fail++;
          $display("FAIL async_reset_drop: gnt=%b busy=%b, want 00/0", gnt2, busy2);
        end
        #1;
        rst = 1'b0;
      end
    end
  endtask

  // ---------------- global time limit ----------------
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
    $fatal(1, "time limit");
  end

  // ---------------- sequence + report ----------------
  initial begin
    cyc2 = 2'b00;
    cyc3 = 3'b000;
    test_reset();
    test_alternation();
    test_no_preempt();
    test_watchdog();
    test_wrap3();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
